// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter for the shared main-memory port.
// One transaction at a time, with a watchdog that aborts stuck accesses.
module mem_port_arbiter #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int BLK_W   = 128,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_read,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_done,
  output logic [BLK_W-1:0]  req0_rdata,
  input  logic              req1_read,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_done,
  output logic [BLK_W-1:0]  req1_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [BLK_W-1:0]  mem_rdata,
  output logic [1:0]        grant,
  output logic              busy,
  output logic              timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RELEASE
  } state_t;

  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic last_q, last_d;
  logic [1:0] grant_q, grant_d;
  logic busy_q, busy_d;
  logic terr_q, terr_d;
  logic done0_q, done0_d;
  logic done1_q, done1_d;
  logic [BLK_W-1:0] rd0_q, rd0_d;
  logic [BLK_W-1:0] rd1_q, rd1_d;
  logic mrd_q, mrd_d;
  logic mwr_q, mwr_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [DATA_W-1:0] mwdata_q, mwdata_d;

  logic want0, want1, pick1;

  assign want0 = req0_read | req0_write;
  assign want1 = req1_read | req1_write;
  // on a tie the port that did not win last time goes next
  assign pick1 = want1 & (~want0 | ~last_q);
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    grant_d  = grant_q;
    busy_d   = busy_q;
    terr_d   = terr_q;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    rd0_d    = rd0_q;
    rd1_d    = rd1_q;
    mrd_d    = mrd_q;
    mwr_d    = mwr_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (want0 | want1) begin
          last_d   = pick1;
          grant_d  = pick1 ? 2'b10 : 2'b01;
          mwr_d    = pick1 ? req1_write : req0_write;
          mrd_d    = pick1 ? (req1_read & ~req1_write)
                           : (req0_read & ~req0_write);
          maddr_d  = pick1 ? req1_addr : req0_addr;
          mwdata_d = pick1 ? req1_wdata : req0_wdata;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = S_ACCESS;
        end
      end
      S_ACCESS: begin
        cnt_d = cnt_inc;
        if (mem_ready || cnt_q == CNT_LAST) begin
          done0_d = ~last_q;
          done1_d = last_q;
          mrd_d   = 1'b0;
          mwr_d   = 1'b0;
          grant_d = 2'b00;
          state_d = S_RELEASE;
          if (!mem_ready) begin
            terr_d = 1'b1;
          end else if (mrd_q) begin
            if (last_q) rd1_d = mem_rdata;
            else        rd0_d = mem_rdata;
          end
        end
      end
      S_RELEASE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      last_q   <= 1'b1;
      grant_q  <= 2'b00;
      busy_q   <= 1'b0;
      terr_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      rd0_q    <= '0;
      rd1_q    <= '0;
      mrd_q    <= 1'b0;
      mwr_q    <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      grant_q  <= grant_d;
      busy_q   <= busy_d;
      terr_q   <= terr_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      rd0_q    <= rd0_d;
      rd1_q    <= rd1_d;
      mrd_q    <= mrd_d;
      mwr_q    <= mwr_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
    end
  end

  assign req0_done   = done0_q;
  assign req1_done   = done1_q;
  assign req0_rdata  = rd0_q;
  assign req1_rdata  = rd1_q;
  assign mem_read    = mrd_q;
  assign mem_write   = mwr_q;
  assign mem_addr    = maddr_q;
  assign mem_wdata   = mwdata_q;
  assign grant       = grant_q;
  assign busy        = busy_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, hand sequences for
// reset/fairness, and random transactions against a reference model.
module tb_mem_port_arbiter;

  localparam int TO = 15;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_read, req0_write;
  logic [9:0]   req0_addr;
  logic [31:0]  req0_wdata;
  logic         req0_done;
  logic [127:0] req0_rdata;
  logic         req1_read, req1_write;
  logic [9:0]   req1_addr;
  logic [31:0]  req1_wdata;
  logic         req1_done;
  logic [127:0] req1_rdata;
  logic         mem_read, mem_write;
  logic [9:0]   mem_addr;
  logic [31:0]  mem_wdata;
  logic         mem_ready;
  logic [127:0] mem_rdata;
  logic [1:0]   grant;
  logic         busy;
  logic         timeout_err;

  mem_port_arbiter #(
    .ADDR_W(10), .DATA_W(32), .BLK_W(128), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .req0_read(req0_read), .req0_write(req0_write),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_done(req0_done), .req0_rdata(req0_rdata),
    .req1_read(req1_read), .req1_write(req1_write),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_done(req1_done), .req1_rdata(req1_rdata),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .grant(grant), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         r0, w0, r1, w1;
    logic [9:0]   a0, a1;
    logic [31:0]  d0, d1;
    int           lat;
    logic [127:0] blk;
    logic [1:0]   g;
    logic         rd, wr;
  } vec_t;

  vec_t tv [12];

  int checks = 0;
  int errors = 0;

  // reference model state
  logic         m_last;
  logic         m_terr;
  logic [127:0] m_rdata [2];

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic vec_t mk(
    input logic r0, w0, r1, w1,
    input logic [9:0] a0, a1,
    input logic [31:0] d0, d1,
    input int lat, input logic [1:0] g,
    input logic rd, wr);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.r1 = r1; v.w1 = w1;
    v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
    v.lat = lat; v.g = g; v.rd = rd; v.wr = wr;
    v.blk = {44'hA5A_5A5A_5A5A, a0, a1, d0, d1};
    return v;
  endfunction

  task automatic model_reset();
    m_last = 1'b1;
    m_terr = 1'b0;
    m_rdata[0] = '0;
    m_rdata[1] = '0;
  endtask

  task automatic drop_reqs();
    req0_read = 1'b0; req0_write = 1'b0;
    req1_read = 1'b0; req1_write = 1'b0;
  endtask

  task automatic txn(input vec_t v);
    logic p1;
    logic [9:0] ea;
    logic [31:0] ed;
    int eff, cyc;
    bit tmo, fin;
    p1 = v.g[1];
    ea = p1 ? v.a1 : v.a0;
    ed = p1 ? v.d1 : v.d0;
    tmo = v.lat > TO;
    eff = tmo ? TO : v.lat;
    @(negedge clk);
    req0_read = v.r0; req0_write = v.w0;
    req1_read = v.r1; req1_write = v.w1;
    req0_addr = v.a0; req1_addr = v.a1;
    req0_wdata = v.d0; req1_wdata = v.d1;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    chk("grant", grant, v.g);
    chk("mem_read", mem_read, v.rd);
    chk("mem_write", mem_write, v.wr);
    chk("mem_addr", mem_addr, ea);
    chk("mem_wdata", mem_wdata, ed);
    chk("busy_acc", busy, 1'b1);
    cyc = 1;
    fin = 0;
    while (!fin) begin
      req0_addr = 10'($urandom);
      req1_addr = 10'($urandom);
      req0_wdata = $urandom;
      req1_wdata = $urandom;
      if ($urandom_range(0, 3) == 0) drop_reqs();
      mem_ready = (cyc == v.lat);
      mem_rdata = mem_ready ? v.blk : rnd128();
      @(posedge clk); #1;
      mem_ready = 1'b0;
      if (req0_done | req1_done) begin
        fin = 1;
      end else begin
        chk("hold_addr", mem_addr, ea);
        chk("hold_wdata", mem_wdata, ed);
        cyc++;
        if (cyc > 60) begin
          checks++;
          errors++;
          $display("FAIL done_wait no done after %0d", cyc);
          fin = 1;
        end
      end
    end
    if (!tmo && v.rd) m_rdata[p1] = v.blk;
    if (tmo) m_terr = 1'b1;
    m_last = p1;
    chk("access_cycles", cyc, eff);
    chk("done0", req0_done, !p1);
    chk("done1", req1_done, p1);
    chk("grant_rel", grant, 2'b00);
    chk("busy_rel", busy, 1'b1);
    chk("strobes_rel", {mem_read, mem_write}, 2'b00);
    chk("rdata0", req0_rdata, m_rdata[0]);
    chk("rdata1", req1_rdata, m_rdata[1]);
    chk("timeout_err", timeout_err, m_terr);
    drop_reqs();
    @(posedge clk); #1;
    chk("busy_idle", busy, 1'b0);
    chk("done_idle", {req0_done, req1_done}, 2'b00);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_grant"}, grant, 2'b00);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_strb"}, {mem_read, mem_write}, 2'b00);
    chk({tag, "_addr"}, mem_addr, 10'h0);
    chk({tag, "_wdata"}, mem_wdata, 32'h0);
    chk({tag, "_done"}, {req0_done, req1_done}, 2'b00);
    chk({tag, "_rd0"}, req0_rdata, 128'h0);
    chk({tag, "_rd1"}, req1_rdata, 128'h0);
    chk({tag, "_terr"}, timeout_err, 1'b0);
  endtask

  initial begin
    vec_t v;
    logic q0, q1, p1, ow;
    logic [127:0] b;
    int n;

    tv[0]  = mk(1, 0, 0, 0, 10'h12A, 10'h000,
                32'h0, 32'h0, 4, 2'b01, 1, 0);
    tv[0].blk = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    tv[1]  = mk(0, 0, 0, 1, 10'h000, 10'h03F,
                32'h0, 32'hAA, 3, 2'b10, 0, 1);
    tv[2]  = mk(1, 0, 1, 0, 10'h011, 10'h022,
                32'h1, 32'h2, 2, 2'b01, 1, 0);
    tv[3]  = mk(1, 0, 1, 0, 10'h033, 10'h044,
                32'h3, 32'h4, 1, 2'b10, 1, 0);
    tv[4]  = mk(1, 1, 0, 0, 10'h055, 10'h000,
                32'h5, 32'h0, 2, 2'b01, 0, 1);
    tv[5]  = mk(1, 0, 0, 0, 10'h066, 10'h000,
                32'h6, 32'h0, 20, 2'b01, 1, 0);
    tv[6]  = mk(0, 0, 1, 0, 10'h000, 10'h077,
                32'h0, 32'h7, 15, 2'b10, 1, 0);
    tv[7]  = mk(0, 1, 0, 1, 10'h088, 10'h099,
                32'h8, 32'h9, 5, 2'b01, 0, 1);
    tv[8]  = mk(0, 1, 0, 0, 10'h0AA, 10'h000,
                32'hA, 32'h0, 16, 2'b01, 0, 1);
    tv[9]  = mk(1, 0, 1, 1, 10'h0BB, 10'h0CC,
                32'hB, 32'hC, 2, 2'b10, 0, 1);
    tv[10] = mk(0, 0, 1, 0, 10'h000, 10'h0DD,
                32'h0, 32'hD, 3, 2'b10, 1, 0);
    tv[11] = mk(1, 0, 1, 0, 10'h0EE, 10'h0FF,
                32'hE, 32'hF, 1, 2'b01, 1, 0);

    rst = 1'b0;
    drop_reqs();
    req0_addr = '0; req1_addr = '0;
    req0_wdata = '0; req1_wdata = '0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk_all_zero("por");
    rst = 1'b1;

    foreach (tv[i]) txn(tv[i]);

    // async reset in the second ACCESS cycle
    @(negedge clk);
    req0_read = 1'b1;
    req0_addr = 10'h155;
    @(posedge clk);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk_all_zero("mid_rst");
    drop_reqs();
    model_reset();
    @(negedge clk);
    chk("mid_rst_nodone", {req0_done, req1_done}, 2'b00);
    rst = 1'b1;

    // both ports hold read requests: grants must alternate from port 0
    req0_read = 1'b1; req0_addr = 10'h101;
    req1_read = 1'b1; req1_addr = 10'h202;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      do begin
        @(posedge clk); #1;
        n++;
      end while (grant == 2'b00 && n < 20);
      ow = k[0];
      chk("fair_grant", grant, ow ? 2'b10 : 2'b01);
      b = {96'h0, 32'hFA110000} + 128'(k);
      mem_ready = 1'b1;
      mem_rdata = b;
      @(posedge clk); #1;
      mem_ready = 1'b0;
      chk("fair_done", {req1_done, req0_done},
          ow ? 2'b10 : 2'b01);
      m_rdata[ow] = b;
    end
    drop_reqs();
    m_last = 1'b1;
    @(posedge clk); #1;
    chk("fair_rd0", req0_rdata, m_rdata[0]);
    chk("fair_rd1", req1_rdata, m_rdata[1]);

    for (int t = 0; t < 300; t++) begin
      do begin
        v.r0 = 1'($urandom); v.w0 = 1'($urandom);
        v.r1 = 1'($urandom); v.w1 = 1'($urandom);
      end while (!(v.r0 | v.w0 | v.r1 | v.w1));
      v.a0 = 10'($urandom); v.a1 = 10'($urandom);
      v.d0 = $urandom; v.d1 = $urandom;
      v.lat = $urandom_range(1, 18);
      v.blk = rnd128();
      q0 = v.r0 | v.w0;
      q1 = v.r1 | v.w1;
      p1 = q1 && (!q0 || !m_last);
      v.g = p1 ? 2'b10 : 2'b01;
      v.wr = p1 ? v.w1 : v.w0;
      v.rd = (p1 ? v.r1 : v.r0) && !v.wr;
      txn(v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
